// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and widths for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int BURST_CNT_W = 8;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder (first set bit at or above ptr, with wrap)
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] j;

    // Scan from the farthest slot back to ptr so the closest hit is written last
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr) + k) % N);
            if (mask[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write-port arbiter with burst lock; FIFO_ARB_STATS_EN adds stall counters
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     fifo_enq,
    output logic [WIDTH-1:0]         fifo_din,
    input  logic                     fifo_full,
    output logic [IDX_W-1:0]         owner,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic                     locked
);

    arb_state_t             state, state_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt, burst_inc;
    logic [IDX_W-1:0]       rr_ptr, rr_idx, win_idx, ptr_nxt;
    logic [NUM_REQ-1:0]     elig;
    logic                   rr_valid, win_valid, do_grant;

    // A requester just granted still shows its old data this cycle, so skip it
    assign elig   = req & ~gnt;
    assign locked = (state == OWNED);

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask  (elig),
        .ptr   (rr_ptr),
        .valid (rr_valid),
        .idx   (rr_idx)
    );

    // Winner choice, grant qualification and burst-lock next state
    always_comb begin
        win_idx   = rr_idx;
        win_valid = rr_valid;
        if (state == OWNED) begin
            win_idx   = owner;
            win_valid = elig[owner];
        end
        // full lags the write by a cycle, so never issue back-to-back writes
        do_grant  = win_valid && !fifo_full && !fifo_enq;
        burst_inc = (state == OWNED) ? burst_cnt + BURST_CNT_W'(1) : BURST_CNT_W'(1);
        ptr_nxt   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        state_nxt = state;
        burst_nxt = burst_cnt;
        if (do_grant) begin
            if (lock[win_idx] && (burst_inc < BURST_CNT_W'(MAX_BURST))) begin
                state_nxt = OWNED;
                burst_nxt = burst_inc;
            end else begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        end else if ((state == OWNED) && !req[owner] && !fifo_full) begin
            state_nxt = IDLE;
            burst_nxt = '0;
        end
    end

    // State, round-robin pointer and registered FIFO write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            gnt       <= '0;
            fifo_enq  <= 1'b0;
            fifo_din  <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            fifo_enq  <= do_grant;
            gnt       <= '0;
            if (do_grant) begin
                gnt      <= NUM_REQ'(1) << win_idx;
                fifo_din <= req_data[win_idx*WIDTH +: WIDTH];
                owner    <= win_idx;
                rr_ptr   <= ptr_nxt;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
        // Saturating count of cycles requester i asked but was not granted
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] <= '0;
            end else if (req[i] && !(do_grant && (win_idx == IDX_W'(i)))
                         && (stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] != '1)) begin
                stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] <=
                    stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] + STALL_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  lock = '0;
    logic [7:0]  d0 = '0;
    logic [7:0]  d1 = '0;
    logic [1:0]  gnt;
    logic        fifo_enq;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        full_drv = 1'b0;
    logic [0:0]  owner;
    logic        locked;
`ifdef FIFO_ARB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    // small FIFO model, 8 deep
    logic       use_model = 1'b0;
    logic       deq = 1'b0;
    logic [7:0] q[$];
    int         qcnt = 0;
    logic       ovf = 1'b0;

    assign fifo_full = use_model ? (qcnt >= 8) : full_drv;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(2), .MAX_BURST(16)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req       (req),
        .lock      (lock),
        .req_data  ({d1, d0}),
        .gnt       (gnt),
        .fifo_enq  (fifo_enq),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .owner     (owner),
`ifdef FIFO_ARB_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .locked    (locked)
    );

    always @(posedge clk) begin
        if (use_model) begin
            if (deq && q.size() > 0) void'(q.pop_front());
            if (fifo_enq) begin
                if (q.size() >= 8) ovf = 1'b1;
                else q.push_back(fifo_din);
            end
            qcnt <= q.size();
        end
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] lock;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       full;
        logic [1:0] gnt;
        logic       enq;
        logic [7:0] din;
        logic       own;
        logic       lkd;
    } vec_t;

    vec_t       vt[25];
    logic       gw[18];
    logic [7:0] gd[18];
    logic       gl[18];
    int         ng;
    int         enq_n;

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; lock = '0; full_drv = 1'b0; deq = 1'b0;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_enq", fifo_enq, 0);
        check("rst_din", fifo_din, 0);
        check("rst_owner", owner, 0);
        check("rst_locked", locked, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        //          req    lock   d0     d1     full  gnt    enq   din    own   lkd
        vt[0]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{2'b01, 2'b00, 8'h11, 8'h00, 1'b0, 2'b01, 1'b1, 8'h11, 1'b0, 1'b0};
        vt[2]  = '{2'b00, 2'b00, 8'h11, 8'h00, 1'b0, 2'b00, 1'b0, 8'h11, 1'b0, 1'b0};
        vt[3]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b10, 1'b1, 8'hB0, 1'b1, 1'b0};
        vt[4]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hB0, 1'b1, 1'b0};
        vt[5]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hA0, 1'b0, 1'b0};
        vt[6]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hA0, 1'b0, 1'b0};
        vt[7]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b10, 1'b1, 8'hB0, 1'b1, 1'b0};
        vt[8]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 2'b00, 1'b0, 8'hB0, 1'b1, 1'b0};
        vt[9]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 2'b00, 1'b0, 8'hB0, 1'b1, 1'b0};
        vt[10] = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hA0, 1'b0, 1'b0};
        vt[11] = '{2'b01, 2'b01, 8'hA0, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hA0, 1'b0, 1'b0};
        vt[12] = '{2'b01, 2'b01, 8'hC1, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hC1, 1'b0, 1'b1};
        vt[13] = '{2'b11, 2'b01, 8'hC2, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hC1, 1'b0, 1'b1};
        vt[14] = '{2'b11, 2'b01, 8'hC2, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hC2, 1'b0, 1'b1};
        vt[15] = '{2'b11, 2'b01, 8'hC3, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hC2, 1'b0, 1'b1};
        vt[16] = '{2'b11, 2'b00, 8'hC3, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hC3, 1'b0, 1'b0};
        vt[17] = '{2'b11, 2'b00, 8'hC3, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hC3, 1'b0, 1'b0};
        vt[18] = '{2'b11, 2'b00, 8'hC3, 8'hB0, 1'b0, 2'b10, 1'b1, 8'hB0, 1'b1, 1'b0};
        vt[19] = '{2'b00, 2'b00, 8'hC3, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hB0, 1'b1, 1'b0};
        vt[20] = '{2'b01, 2'b01, 8'hD0, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hD0, 1'b0, 1'b1};
        vt[21] = '{2'b00, 2'b01, 8'hD0, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hD0, 1'b0, 1'b0};
        vt[22] = '{2'b01, 2'b01, 8'hD1, 8'hB0, 1'b0, 2'b01, 1'b1, 8'hD1, 1'b0, 1'b1};
        vt[23] = '{2'b00, 2'b01, 8'hD1, 8'hB0, 1'b1, 2'b00, 1'b0, 8'hD1, 1'b0, 1'b1};
        vt[24] = '{2'b00, 2'b01, 8'hD1, 8'hB0, 1'b0, 2'b00, 1'b0, 8'hD1, 1'b0, 1'b0};

        do_reset();
        for (int k = 0; k < 25; k++) begin
            req = vt[k].req; lock = vt[k].lock; d0 = vt[k].d0; d1 = vt[k].d1; full_drv = vt[k].full;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_gnt", k), gnt, vt[k].gnt);
            check($sformatf("v%0d_enq", k), fifo_enq, vt[k].enq);
            check($sformatf("v%0d_din", k), fifo_din, vt[k].din);
            check($sformatf("v%0d_owner", k), owner, vt[k].own);
            check($sformatf("v%0d_locked", k), locked, vt[k].lkd);
        end

        // burst lock: 16 grants to 0, forced release, then 1, then 0 again
        do_reset();
        req = 2'b11; lock = 2'b01; d0 = 8'h00; d1 = 8'hB5; ng = 0;
        for (int c = 0; c < 200 && ng < 18; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt != 2'b00) begin
                gw[ng] = gnt[1]; gd[ng] = fifo_din; gl[ng] = locked; ng++;
                if (gnt[0]) d0 = d0 + 8'h01;
            end
        end
        check("burst_grants", ng, 18);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("burst%0d_who", k), gw[k], (k == 16) ? 1 : 0);
            check($sformatf("burst%0d_din", k), gd[k], (k < 16) ? k : ((k == 16) ? 8'hB5 : 8'h10));
            check($sformatf("burst%0d_locked", k), gl[k], (k < 15 || k == 17) ? 1 : 0);
        end
        req = '0; lock = '0;

        // fill an 8-deep FIFO, then free one slot
        do_reset();
        q.delete(); ovf = 1'b0; use_model = 1'b1;
        req = 2'b01; d0 = 8'h40; enq_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (fifo_enq) enq_n++;
            if (gnt[0]) d0 = d0 + 8'h01;
        end
        check("fill_enq", enq_n, 8);
        check("fill_size", q.size(), 8);
        check("fill_full", fifo_full, 1);
        deq = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            deq = 1'b0;
            if (fifo_enq) enq_n++;
            if (gnt[0]) d0 = d0 + 8'h01;
        end
        check("refill_enq", enq_n, 9);
        check("overflow", ovf, 0);
        check("refill_size", q.size(), 8);
        for (int k = 0; k < 8 && k < q.size(); k++)
            check($sformatf("fifo_data%0d", k), q[k], 8'h41 + k);
        req = '0; use_model = 1'b0;

        // reset in the middle of a locked burst
        do_reset();
        req = 2'b01; lock = 2'b01; d0 = 8'h50; ng = 0;
        for (int c = 0; c < 50 && ng < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt[0]) begin ng++; d0 = d0 + 8'h01; end
        end
        check("mid_grants", ng, 5);
        check("mid_locked_pre", locked, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_enq", fifo_enq, 0);
        check("mid_gnt", gnt, 0);
        check("mid_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1; req = 2'b11; lock = 2'b00; d0 = 8'h60; d1 = 8'h61; ng = 0;
        for (int c = 0; c < 10 && ng == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt != 2'b00) begin
                ng = 1;
                check("post_gnt", gnt, 2'b01);
                check("post_din", fifo_din, 8'h60);
            end
        end
        check("post_granted", ng, 1);
        req = '0;

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        req = 2'b10; full_drv = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall1", stall_cnt[31:16], 10);
        check("stall0", stall_cnt[15:0], 0);
        req = '0; full_drv = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
